// File: rtl/pong_sequencer_pkg.sv
// Shared types and helpers for the Pong game-flow sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    MISS      = 3'd4,
    GAME_OVER = 3'd5
  } seq_state_t;

  localparam logic [1:0] BG_NORMAL  = 2'b00;
  localparam logic [1:0] BG_FLASH   = 2'b01;
  localparam logic [1:0] BG_OVER    = 2'b10;
  localparam logic [1:0] BG_ATTRACT = 2'b11;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/pong_sequencer_if.sv
// Game-side signal bundle between the sequencer and the Pong datapath.
interface pong_sequencer_if;
  logic       frame_start;
  logic       btn_raw;
  logic       ball_hit;
  logic       ball_miss;
  logic       game_run;
  logic       ball_hold;
  logic [1:0] bg_sel;
  logic [7:0] score_bcd;
  logic [1:0] lives;
  logic [2:0] state_dbg;

  modport master (
    output frame_start, btn_raw, ball_hit, ball_miss,
    input  game_run, ball_hold, bg_sel, score_bcd, lives, state_dbg
  );

  modport slave (
    input  frame_start, btn_raw, ball_hit, ball_miss,
    output game_run, ball_hold, bg_sel, score_bcd, lives, state_dbg
  );
endinterface

// File: rtl/pong_sequencer_btn_debounce.sv
// Serve/pause button: 2-flop synchroniser and frame-rate debounce producing a
// one-cycle press pulse on an accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_start,
  input  logic btn_raw,
  output logic press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic          sync1_q, sync2_q;
  logic          cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (frame_start) begin
      if (sync2_q == cand_q) begin
        if (cnt_q != CW'(DEBOUNCE_FRAMES)) cnt_d = cnt_q + CW'(1);
      end else begin
        cand_d = sync2_q;
        cnt_d  = CW'(1);
      end
      // A run long enough to accept a new level; only a rising one is a press.
      if (cnt_d == CW'(DEBOUNCE_FRAMES) && cand_d != level_q) begin
        level_d = cand_d;
        press_d = cand_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/pong_sequencer.sv
// Pong game-flow controller: phase FSM, frame timer, BCD score and lives,
// with registered motion-gate and background-mode outputs.
module pong_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned LIVES           = 3,
  parameter int unsigned SERVE_FRAMES    = 60,
  parameter int unsigned FLASH_FRAMES    = 30,
  parameter int unsigned GAMEOVER_FRAMES = 600,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input logic             clk,
  input logic             reset_n,
  pong_sequencer_if.slave bus
);
  localparam int unsigned TMAX_A = (SERVE_FRAMES > FLASH_FRAMES) ? SERVE_FRAMES : FLASH_FRAMES;
  localparam int unsigned TMAX   = (TMAX_A > GAMEOVER_FRAMES) ? TMAX_A : GAMEOVER_FRAMES;
  localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  seq_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic          run_q, run_d;
  logic          hold_q, hold_d;
  logic [1:0]    bg_q, bg_d;
  logic          press;

  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_btn (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (bus.frame_start),
    .btn_raw     (bus.btn_raw),
    .press       (press)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    score_d = score_q;
    lives_d = lives_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d = SERVE;
          score_d = '0;
          lives_d = 2'(LIVES);
          timer_d = TW'(SERVE_FRAMES - 1);
        end
      end
      SERVE: begin
        if (bus.frame_start) begin
          if (timer_q == '0) state_d = PLAY;
          else               timer_d = timer_q - TW'(1);
        end
      end
      PLAY: begin
        if (bus.ball_miss) begin
          state_d = MISS;
          lives_d = lives_q - 2'd1;
          timer_d = TW'(FLASH_FRAMES - 1);
        end else if (press) begin
          state_d = PAUSE;
        end else if (bus.ball_hit) begin
          score_d = bcd_inc_sat(score_q);
        end
      end
      PAUSE: begin
        if (press) state_d = PLAY;
      end
      MISS: begin
        if (bus.frame_start) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (lives_q == 2'd0) begin
            state_d = GAME_OVER;
            timer_d = TW'(GAMEOVER_FRAMES - 1);
          end else begin
            state_d = SERVE;
            timer_d = TW'(SERVE_FRAMES - 1);
          end
        end
      end
      GAME_OVER: begin
        // A press starts a new game and wins over a coincident timeout.
        if (press) begin
          state_d = SERVE;
          score_d = '0;
          lives_d = 2'(LIVES);
          timer_d = TW'(SERVE_FRAMES - 1);
        end else if (bus.frame_start) begin
          if (timer_q == '0) state_d = IDLE;
          else               timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    run_d  = (state_d == PLAY);
    hold_d = !(state_d == PLAY || state_d == PAUSE);
    unique case (state_d)
      MISS:      bg_d = BG_FLASH;
      GAME_OVER: bg_d = BG_OVER;
      IDLE:      bg_d = BG_ATTRACT;
      default:   bg_d = BG_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      score_q <= '0;
      lives_q <= '0;
      run_q   <= 1'b0;
      hold_q  <= 1'b1;
      bg_q    <= BG_ATTRACT;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      score_q <= score_d;
      lives_q <= lives_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      bg_q    <= bg_d;
    end
  end

  assign bus.game_run  = run_q;
  assign bus.ball_hold = hold_q;
  assign bus.bg_sel    = bg_q;
  assign bus.score_bcd = score_q;
  assign bus.lives     = lives_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_pong_sequencer.sv
// Randomized scoreboard bench for pong_sequencer against a frame-level game model.
module tb_pong_sequencer;
  import pong_pkg::*;

  localparam int unsigned P_LIVES = 2;
  localparam int unsigned P_SERVE = 4;
  localparam int unsigned P_FLASH = 2;
  localparam int unsigned P_GO    = 5;
  localparam int unsigned P_DEB   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pong_sequencer_if bus();

  pong_sequencer #(
    .LIVES(P_LIVES), .SERVE_FRAMES(P_SERVE), .FLASH_FRAMES(P_FLASH),
    .GAMEOVER_FRAMES(P_GO), .DEBOUNCE_FRAMES(P_DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct { int st; int score; int lives; int tag; } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int frames = 0;

  // Game model: phase, score as a plain integer, lives, frames left in phase,
  // and the button as a history of per-frame samples.
  int m_st, m_score, m_lives, m_left;
  int d_last, d_run, d_level;
  exp_t m_prev;

  function automatic logic [7:0] to_bcd(input int s);
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  function automatic logic [16:0] exp_vec(input exp_t e);
    logic [1:0] bg;
    if (e.st == MISS)           bg = 2'b01;
    else if (e.st == GAME_OVER) bg = 2'b10;
    else if (e.st == IDLE)      bg = 2'b11;
    else                        bg = 2'b00;
    return {3'(e.st), (e.st == PLAY), !(e.st == PLAY || e.st == PAUSE), bg,
            to_bcd(e.score), 2'(e.lives)};
  endfunction

  function void m_publish();
    exp_t e;
    e.st = m_st; e.score = m_score; e.lives = m_lives; e.tag = frames;
    if (e.st != m_prev.st || e.score != m_prev.score || e.lives != m_prev.lives) begin
      exp_q.push_back(e);
      m_prev = e;
    end
  endfunction

  function void m_reset();
    m_st = IDLE; m_score = 0; m_lives = 0; m_left = 0;
    d_last = 0; d_run = 0; d_level = 0;
    m_publish();
  endfunction

  function void m_new_game();
    m_st = SERVE; m_score = 0; m_lives = P_LIVES; m_left = P_SERVE;
  endfunction

  function void m_event(input bit hit, input bit miss);
    if (m_st != PLAY) return;
    if (miss) begin
      m_lives = m_lives - 1;
      m_st = MISS;
      m_left = P_FLASH;
    end else if (hit && m_score < 99) begin
      m_score = m_score + 1;
    end
    m_publish();
  endfunction

  function void m_frame(input bit b);
    bit press;
    if (m_st == SERVE || m_st == MISS || m_st == GAME_OVER) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_st == SERVE) m_st = PLAY;
        else if (m_st == GAME_OVER) m_st = IDLE;
        else if (m_lives == 0) begin m_st = GAME_OVER; m_left = P_GO; end
        else begin m_st = SERVE; m_left = P_SERVE; end
      end
      m_publish();
    end
    if (int'(b) == d_last) d_run = d_run + 1;
    else begin d_last = int'(b); d_run = 1; end
    press = 1'b0;
    if (d_run >= P_DEB && d_last != d_level) begin
      d_level = d_last;
      press = (d_level == 1);
    end
    if (press) begin
      if (m_st == IDLE || m_st == GAME_OVER) m_new_game();
      else if (m_st == PLAY) m_st = PAUSE;
      else if (m_st == PAUSE) m_st = PLAY;
      m_publish();
    end
  endfunction

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h (frame %0d)", name, got, want, frames);
    end
  endtask

  // Monitor: every change of the output set must match the next expected
  // snapshot, including the frame in which it happens.
  logic [16:0] obs, last_obs;
  bit mon_en = 1'b0;
  assign obs = {bus.state_dbg, bus.game_run, bus.ball_hold, bus.bg_sel, bus.score_bcd, bus.lives};

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [16:0] want;
    if (mon_en && obs !== last_obs) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change got=%h at frame %0d, want=no change", obs, frames);
      end else begin
        e = exp_q.pop_front();
        want = exp_vec(e);
        if (obs !== want || e.tag != frames) begin
          miscompares++;
          $display("FAIL transition got=%h at frame %0d, want=%h at frame %0d",
                   obs, frames, want, e.tag);
        end
      end
      last_obs = obs;
    end
  end

  // One 100-cycle frame: optional hits every other cycle from offset 10,
  // optional miss (ev=1) or hit+miss (ev=2) at 95, frame_start at 99.
  task automatic run_frame(input logic btn, input int n_hits, input int ev);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.frame_start = 1'b0;
      bus.ball_hit    = 1'b0;
      bus.ball_miss   = 1'b0;
      if (c == 0) bus.btn_raw = btn;
      if (c >= 10 && c < 10 + 2 * n_hits && (c % 2) == 0) begin
        bus.ball_hit = 1'b1;
        m_event(1'b1, 1'b0);
      end
      if (c == 95 && ev != 0) begin
        bus.ball_miss = 1'b1;
        bus.ball_hit  = (ev == 2);
        m_event(ev == 2, 1'b1);
      end
      if (c == 99) begin
        bus.frame_start = 1'b1;
        frames++;
        m_frame(btn);
      end
    end
  endtask

  task automatic saturate_hits(input int total);
    int rem, n;
    rem = total;
    while (rem > 0) begin
      n = $urandom_range(1, 40);
      if (n > rem) n = rem;
      run_frame(1'b0, n, 0);
      rem -= n;
    end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.btn_raw     = 1'b0;
    bus.ball_hit    = 1'b0;
    bus.ball_miss   = 1'b0;
    m_prev = '{st: IDLE, score: 0, lives: 0, tag: 0};
    m_st = IDLE; m_score = 0; m_lives = 0; m_left = 0;
    d_last = 0; d_run = 0; d_level = 0;

    repeat (3) @(negedge clk);
    check("rst_state", int'(bus.state_dbg), IDLE);
    check("rst_run",   int'(bus.game_run), 0);
    check("rst_hold",  int'(bus.ball_hold), 1);
    check("rst_bg",    int'(bus.bg_sel), 3);
    check("rst_score", int'(bus.score_bcd), 0);
    check("rst_lives", int'(bus.lives), 0);
    reset_n = 1'b1;
    #1;
    last_obs = obs;
    mon_en = 1'b1;

    // Press from IDLE, SERVE lasts four frames with stray events ignored.
    run_frame(1'b1, $urandom_range(0, 3), 0);
    run_frame(1'b1, 0, 0);
    repeat (3) run_frame(1'b0, $urandom_range(0, 3), $urandom_range(0, 2));
    check("run_before_4th", int'(bus.game_run), 0);
    run_frame(1'b0, 0, 0);
    @(posedge clk); #1;
    check("run_after_4th", int'(bus.game_run), 1);
    check("serve_lives", int'(bus.lives), 2);
    check("serve_score", int'(bus.score_bcd), 0);

    // Eleven hits, then coincident hit+miss.
    run_frame(1'b0, 11, 0);
    check("score_11", int'(bus.score_bcd), 'h11);
    run_frame(1'b0, 0, 2);
    check("miss_bg", int'(bus.bg_sel), 1);
    check("miss_lives", int'(bus.lives), 1);
    check("miss_score", int'(bus.score_bcd), 'h11);
    run_frame(1'b0, 0, 0);
    @(posedge clk); #1;
    check("flash_done", int'(bus.state_dbg), SERVE);
    repeat (P_SERVE) run_frame(1'b0, $urandom_range(0, 5), 0);

    // Pause, ignored events, release, glitch, resume.
    run_frame(1'b1, 0, 0);
    run_frame(1'b1, 0, 0);
    run_frame(1'b1, $urandom_range(1, 20), 1);
    check("pause_run", int'(bus.game_run), 0);
    check("pause_score", int'(bus.score_bcd), int'(to_bcd(m_score)));
    run_frame(1'b0, 5, 0);
    run_frame(1'b0, 5, 0);
    run_frame(1'b1, 5, 0);
    run_frame(1'b0, 5, 0);
    check("glitch_no_press", int'(bus.state_dbg), PAUSE);
    run_frame(1'b1, 0, 0);
    run_frame(1'b1, 0, 0);
    run_frame(1'b0, 0, 0);
    run_frame(1'b0, 0, 0);
    check("resumed", int'(bus.state_dbg), PLAY);

    // Saturate the score, then hold.
    saturate_hits(99 - m_score);
    check("score_99", int'(bus.score_bcd), 'h99);
    saturate_hits($urandom_range(1, 30));
    check("score_hold", int'(bus.score_bcd), 'h99);

    // Last life lost: MISS, GAME_OVER, timeout to IDLE.
    run_frame(1'b0, $urandom_range(0, 5), 1);
    run_frame(1'b0, 0, 0);
    @(posedge clk); #1;
    check("over_bg", int'(bus.bg_sel), 2);
    repeat (P_GO) run_frame(1'b0, $urandom_range(0, 3), $urandom_range(0, 1));
    @(posedge clk); #1;
    check("back_idle", int'(bus.state_dbg), IDLE);
    check("score_kept", int'(bus.score_bcd), 'h99);

    // Second game ending with a press during GAME_OVER.
    run_frame(1'b1, 0, 0);
    run_frame(1'b1, 0, 0);
    repeat (P_SERVE) run_frame(1'b0, $urandom_range(0, 3), 0);
    run_frame(1'b0, $urandom_range(1, 30), 1);
    repeat (1 + P_SERVE) run_frame(1'b0, 0, 0);
    run_frame(1'b0, $urandom_range(1, 30), 1);
    run_frame(1'b0, 0, 0);
    run_frame(1'b1, 0, 0);
    run_frame(1'b1, 0, 0);
    repeat (2) @(posedge clk); #1;
    check("restart_state", int'(bus.state_dbg), SERVE);
    check("restart_score", int'(bus.score_bcd), 0);
    check("restart_lives", int'(bus.lives), 2);
    run_frame(1'b0, 0, 0);

    // Asynchronous reset mid-SERVE while frame_start is high.
    @(negedge clk);
    bus.frame_start = 1'b1;
    m_reset();
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", int'(bus.state_dbg), IDLE);
    check("arst_run",   int'(bus.game_run), 0);
    check("arst_hold",  int'(bus.ball_hold), 1);
    check("arst_bg",    int'(bus.bg_sel), 3);
    check("arst_score", int'(bus.score_bcd), 0);
    check("arst_lives", int'(bus.lives), 0);
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_frame(1'b0, 3, 1);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
